// File: rtl/fft_frame_sequencer_if.sv
// Signal bundle between the frame sequencer and its environment: sample input,
// FFT core in/out streams, peak-finder link and status flags.
interface fft_frame_sequencer_if;
  logic        sample_valid_in;
  logic [15:0] sample_in;
  logic [15:0] fft_in_data_out;
  logic        fft_in_valid_out;
  logic        fft_in_last_out;
  logic        fft_in_ready_in;
  logic [15:0] fft_out_data_in;
  logic        fft_out_valid_in;
  logic        fft_out_last_in;
  logic        pf_rst_out;
  logic        pf_valid_out;
  logic [15:0] pf_data_out;
  logic [11:0] peak_in;
  logic        peak_valid_in;
  logic [11:0] note_bin_out;
  logic        note_valid_out;
  logic        overrun_out;
  logic        timeout_out;

  // Sequencer side.
  modport slave (
    input  sample_valid_in, sample_in, fft_in_ready_in,
           fft_out_data_in, fft_out_valid_in, fft_out_last_in,
           peak_in, peak_valid_in,
    output fft_in_data_out, fft_in_valid_out, fft_in_last_out,
           pf_rst_out, pf_valid_out, pf_data_out,
           note_bin_out, note_valid_out, overrun_out, timeout_out
  );

  // Environment side.
  modport master (
    output sample_valid_in, sample_in, fft_in_ready_in,
           fft_out_data_in, fft_out_valid_in, fft_out_last_in,
           peak_in, peak_valid_in,
    input  fft_in_data_out, fft_in_valid_out, fft_in_last_out,
           pf_rst_out, pf_valid_out, pf_data_out,
           note_bin_out, note_valid_out, overrun_out, timeout_out
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame controller for the pitch path: fills FFT frames, forwards low search bins
// to the peak finder, and debounces returned peaks into a stable note bin.
module fft_frame_sequencer #(
  parameter int FFT_SIZE      = 1024,
  parameter int SEARCH_BINS   = 300,
  parameter int STABLE_FRAMES = 3,
  parameter int TIMEOUT       = 4096
) (
  input logic clk_in,
  input logic rst_in,
  fft_frame_sequencer_if.slave bus
);

  localparam int SCW = $clog2(FFT_SIZE);
  localparam int BCW = $clog2(FFT_SIZE);
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int SW  = $clog2(STABLE_FRAMES + 1);

  localparam logic [SCW-1:0] LAST_SAMPLE = SCW'(FFT_SIZE - 1);
  localparam logic [BCW-1:0] BIN_LAST    = BCW'(SEARCH_BINS);
  localparam logic [BCW-1:0] BIN_SAT     = BCW'(SEARCH_BINS + 1);
  localparam logic [WCW-1:0] WAIT_LAST   = WCW'(TIMEOUT - 1);
  localparam logic [SW-1:0]  STABLE_MAX  = SW'(STABLE_FRAMES);

  typedef enum logic [1:0] {FILL, DRAIN, WAIT_PEAK} state_t;

  state_t         state, state_next;
  logic [SCW-1:0] sample_cnt;
  logic [BCW-1:0] bin_cnt;
  logic [WCW-1:0] wait_cnt;
  logic [SW-1:0]  stable_cnt, stable_next;
  logic [11:0]    prev_peak, prev_next, held_peak, captured;
  logic           peak_valid_q, edge_pending, reported;
  logic           accept, drop, rise, capture, expire, report;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    drop       = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    captured   = bus.peak_in;
    rise       = bus.peak_valid_in && !peak_valid_q;
    case (state)
      FILL: begin
        accept = bus.sample_valid_in && bus.fft_in_ready_in;
        drop   = bus.sample_valid_in && !bus.fft_in_ready_in;
        if (accept && sample_cnt == LAST_SAMPLE) state_next = DRAIN;
      end
      DRAIN: begin
        if (bus.fft_out_valid_in && bus.fft_out_last_in) state_next = WAIT_PEAK;
      end
      WAIT_PEAK: begin
        // An edge seen during DRAIN is consumed here before any live edge.
        capture = rise || edge_pending;
        if (edge_pending) captured = held_peak;
        expire = !capture && (wait_cnt == WAIT_LAST);
        if (capture || expire) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    stable_next = stable_cnt;
    prev_next   = prev_peak;
    report      = 1'b0;
    if (capture) begin
      if (captured == '0) begin
        stable_next = '0;
      end else if (captured == prev_peak) begin
        stable_next = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 1'b1;
      end else begin
        stable_next = SW'(1);
        prev_next   = captured;
      end
      report = (captured != '0) && (stable_next == STABLE_MAX) &&
               (!reported || captured != bus.note_bin_out);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= FILL;
    else        state <= state_next;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sample_cnt           <= '0;
      bin_cnt              <= '0;
      wait_cnt             <= '0;
      stable_cnt           <= '0;
      prev_peak            <= '0;
      held_peak            <= '0;
      peak_valid_q         <= 1'b0;
      edge_pending         <= 1'b0;
      reported             <= 1'b0;
      bus.fft_in_data_out  <= '0;
      bus.fft_in_valid_out <= 1'b0;
      bus.fft_in_last_out  <= 1'b0;
      bus.pf_rst_out       <= 1'b1;
      bus.pf_valid_out     <= 1'b0;
      bus.pf_data_out      <= '0;
      bus.note_bin_out     <= '0;
      bus.note_valid_out   <= 1'b0;
      bus.overrun_out      <= 1'b0;
      bus.timeout_out      <= 1'b0;
    end else begin
      peak_valid_q         <= bus.peak_valid_in;
      bus.fft_in_valid_out <= accept;
      bus.fft_in_last_out  <= accept && (sample_cnt == LAST_SAMPLE);
      if (accept) begin
        bus.fft_in_data_out <= bus.sample_in;
        sample_cnt          <= sample_cnt + 1'b1;
      end

      bus.pf_valid_out <= 1'b0;
      if (state == DRAIN && bus.fft_out_valid_in) begin
        if (bin_cnt <= BIN_LAST) begin
          bus.pf_valid_out <= 1'b1;
          bus.pf_data_out  <= bus.fft_out_data_in;
        end
        if (bus.fft_out_last_in)  bin_cnt <= '0;
        else if (bin_cnt != BIN_SAT) bin_cnt <= bin_cnt + 1'b1;
      end

      if (state == DRAIN && rise) begin
        edge_pending <= 1'b1;
        held_peak    <= bus.peak_in;
      end else if (capture) begin
        edge_pending <= 1'b0;
      end

      wait_cnt       <= (state == WAIT_PEAK) ? wait_cnt + 1'b1 : '0;
      bus.pf_rst_out <= capture || expire;

      stable_cnt         <= stable_next;
      prev_peak          <= prev_next;
      bus.note_valid_out <= report;
      if (report) begin
        bus.note_bin_out <= captured;
        reported         <= 1'b1;
      end

      if (drop)   bus.overrun_out <= 1'b1;
      if (expire) bus.timeout_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer: directed frame scenarios plus
// randomized frames checked against a frame-level reference model.
module tb_fft_frame_sequencer;
  localparam int FFT_SIZE      = 8;
  localparam int SEARCH_BINS   = 4;
  localparam int STABLE_FRAMES = 2;
  localparam int TIMEOUT       = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fft_frame_sequencer_if bus();

  fft_frame_sequencer #(
    .FFT_SIZE(FFT_SIZE), .SEARCH_BINS(SEARCH_BINS),
    .STABLE_FRAMES(STABLE_FRAMES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state, kept at frame/transaction level.
  int          m_acc;
  bit          m_in_fill, m_overrun, m_timeout, m_reported;
  logic [11:0] m_note;
  logic [11:0] hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Length of the trailing run of identical non-zero captured peaks.
  function automatic int trailing_run();
    int r = 0;
    for (int k = hist.size() - 1; k >= 0; k--) begin
      if (hist[k] == 12'd0 || hist[k] != hist[hist.size()-1]) break;
      r++;
    end
    return r;
  endfunction

  task automatic idle_inputs();
    bus.sample_valid_in  = 1'b0;
    bus.sample_in        = '0;
    bus.fft_in_ready_in  = 1'b1;
    bus.fft_out_data_in  = '0;
    bus.fft_out_valid_in = 1'b0;
    bus.fft_out_last_in  = 1'b0;
    bus.peak_in          = '0;
    bus.peak_valid_in    = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    check("rst_pf_rst",   32'(bus.pf_rst_out), 32'd1);
    check("rst_in_valid", 32'(bus.fft_in_valid_out), 32'd0);
    check("rst_in_last",  32'(bus.fft_in_last_out), 32'd0);
    check("rst_pf_valid", 32'(bus.pf_valid_out), 32'd0);
    check("rst_note_bin", 32'(bus.note_bin_out), 32'd0);
    check("rst_note_vld", 32'(bus.note_valid_out), 32'd0);
    check("rst_overrun",  32'(bus.overrun_out), 32'd0);
    check("rst_timeout",  32'(bus.timeout_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_acc = 0; m_in_fill = 1'b1; m_overrun = 1'b0; m_timeout = 1'b0;
    m_reported = 1'b0; m_note = '0;
    hist.delete();
    check("post_rst_pf_rst", 32'(bus.pf_rst_out), 32'd1);
    tick();
    check("post_rst_pf_rst_drop", 32'(bus.pf_rst_out), 32'd0);
  endtask

  // Offers samples; ready is low where lo_mask has a 1. With finish set, keeps
  // offering until the model says the frame is complete.
  task automatic feed_samples(input logic [31:0] lo_mask, input int n_offer, input bit finish);
    int i = 0;
    while ((i < n_offer || (finish && m_in_fill)) && i < 64) begin
      logic        rdy;
      logic [15:0] s;
      bit          acc, lst;
      rdy = (i < 32) ? !lo_mask[i] : 1'b1;
      s   = 16'($urandom);
      bus.sample_valid_in = 1'b1;
      bus.sample_in       = s;
      bus.fft_in_ready_in = rdy;
      acc = m_in_fill && rdy;
      lst = 1'b0;
      if (m_in_fill && !rdy) m_overrun = 1'b1;
      if (acc) begin
        m_acc++;
        if (m_acc == FFT_SIZE) begin
          lst = 1'b1; m_in_fill = 1'b0; m_acc = 0;
        end
      end
      tick();
      check("in_valid", 32'(bus.fft_in_valid_out), 32'(acc));
      check("in_last",  32'(bus.fft_in_last_out), 32'(lst));
      if (acc) check("in_data", 32'(bus.fft_in_data_out), 32'(s));
      check("overrun", 32'(bus.overrun_out), 32'(m_overrun));
      i++;
    end
    bus.sample_valid_in = 1'b0;
    bus.fft_in_ready_in = 1'b1;
  endtask

  // Streams n bins (last on the n-th) with random idle gaps and stray samples.
  task automatic stream_bins(input int n, input bit early, input logic [11:0] p);
    for (int i = 0; i < n; i++) begin
      logic [15:0] d;
      bit          fwd;
      if ($urandom_range(0, 3) == 0) begin
        bus.fft_out_valid_in = 1'b0;
        bus.fft_out_last_in  = 1'b0;
        tick();
        check("pf_idle", 32'(bus.pf_valid_out), 32'd0);
      end
      d = 16'($urandom);
      bus.fft_out_valid_in = 1'b1;
      bus.fft_out_data_in  = d;
      bus.fft_out_last_in  = (i == n - 1);
      bus.sample_valid_in  = 1'($urandom);
      bus.fft_in_ready_in  = 1'($urandom);
      if (early && i == 0) begin
        bus.peak_in       = p;
        bus.peak_valid_in = 1'b1;
      end
      fwd = (i <= SEARCH_BINS);
      tick();
      check("pf_valid", 32'(bus.pf_valid_out), 32'(fwd));
      if (fwd) check("pf_data", 32'(bus.pf_data_out), 32'(d));
      check("drain_in_valid", 32'(bus.fft_in_valid_out), 32'd0);
      check("drain_overrun", 32'(bus.overrun_out), 32'(m_overrun));
    end
    bus.fft_out_valid_in = 1'b0;
    bus.fft_out_last_in  = 1'b0;
    bus.sample_valid_in  = 1'b0;
    bus.fft_in_ready_in  = 1'b1;
  endtask

  task automatic give_peak(input logic [11:0] p, input bit early);
    int run;
    bit exp_rep;
    if (!early) begin
      bus.peak_in       = p;
      bus.peak_valid_in = 1'b1;
    end
    tick();
    hist.push_back(p);
    run     = trailing_run();
    exp_rep = (p != 12'd0) && (run >= STABLE_FRAMES) && (!m_reported || p != m_note);
    if (exp_rep) begin
      m_note = p; m_reported = 1'b1;
    end
    m_in_fill = 1'b1;
    check("note_valid", 32'(bus.note_valid_out), 32'(exp_rep));
    check("note_bin",   32'(bus.note_bin_out), 32'(m_note));
    check("cap_pf_rst", 32'(bus.pf_rst_out), 32'd1);
    tick();
    check("note_valid_drop", 32'(bus.note_valid_out), 32'd0);
    check("pf_rst_width",    32'(bus.pf_rst_out), 32'd0);
    repeat ($urandom_range(0, 2)) tick();
    bus.peak_valid_in = 1'b0;
  endtask

  task automatic wait_timeout();
    for (int c = 1; c <= TIMEOUT; c++) begin
      tick();
      check("to_pf_rst", 32'(bus.pf_rst_out), 32'(c == TIMEOUT));
      check("to_flag",   32'(bus.timeout_out), (c == TIMEOUT) ? 32'd1 : 32'(m_timeout));
      check("to_note",   32'(bus.note_valid_out), 32'd0);
    end
    m_timeout = 1'b1;
    m_in_fill = 1'b1;
    tick();
    check("to_pf_rst_drop", 32'(bus.pf_rst_out), 32'd0);
  endtask

  // mode: 0 = peak after drain, 1 = peak edge during drain, 2 = no peak (timeout)
  task automatic run_frame(input logic [31:0] lo_mask, input int n_offer, input int n_bins,
                           input int mode, input logic [11:0] p);
    feed_samples(lo_mask, n_offer, 1'b1);
    stream_bins(n_bins, mode == 1, p);
    if (mode == 2) wait_timeout();
    else           give_peak(p, mode == 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] picks [4];
    picks[0] = 12'd0; picks[1] = 12'd37; picks[2] = 12'd52; picks[3] = 12'd99;
    idle_inputs();
    #1;
    apply_reset();

    // Mid-frame reset: the next frame counts from zero.
    feed_samples(32'd0, 5, 1'b0);
    apply_reset();
    run_frame(32'd0, 8, 8, 0, 12'd37);

    // Ready low on offered samples 3-4: overrun, last on the 10th offer.
    run_frame(32'b1100, 10, 8, 0, 12'd37);
    check("note_37", 32'(bus.note_bin_out), 32'd37);
    run_frame(32'd0, 8, 8, 1, 12'd37);

    // Stability broken every frame: no report.
    apply_reset();
    run_frame(32'd0, 8, 8, 0, 12'd37);
    run_frame(32'd0, 8, 8, 0, 12'd52);
    run_frame(32'd0, 8, 8, 0, 12'd37);
    run_frame(32'd0, 8, 8, 0, 12'd0);
    run_frame(32'd0, 8, 8, 0, 12'd37);
    check("no_report_bin", 32'(bus.note_bin_out), 32'd0);

    // Timeout, then normal frames resume; a short frame (last before bin 4).
    run_frame(32'd0, 8, 6, 2, 12'd0);
    run_frame(32'd0, 8, 3, 0, 12'd52);
    run_frame(32'd0, 9, 8, 1, 12'd52);
    check("note_52", 32'(bus.note_bin_out), 32'd52);

    for (int f = 0; f < 12; f++) begin
      int m;
      m = $urandom_range(0, 5);
      run_frame($urandom & $urandom & 32'hFFF, 8 + $urandom_range(0, 3),
                $urandom_range(3, 8), (m == 5) ? 2 : (m == 4) ? 1 : 0,
                picks[$urandom_range(0, 3)]);
    end

    check("final_overrun", 32'(bus.overrun_out), 32'(m_overrun));
    check("final_timeout", 32'(bus.timeout_out), 32'(m_timeout));
    check("final_note",    32'(bus.note_bin_out), 32'(m_note));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
